// File: rtl/jt89_cic_decim.sv
// Second-order CIC decimator (M=1, N=2), decimating by 2^RLOG2 with unity DC gain.
// Produces one sample per frame of 2^RLOG2 input enables, handed off through a valid/ready output.
module jt89_cic_decim #(
    parameter int IW    = 11,
    parameter int RLOG2 = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cen,
    input  logic signed [IW-1:0] din,
    output logic signed [IW-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 overflow
);
    localparam int W = IW + 2*RLOG2;

    logic signed [W-1:0]  integ1, integ2, dly1, dly2;
    logic signed [W-1:0]  din_ext, c1, c2;
    logic signed [IW-1:0] c2_q;
    logic [RLOG2-1:0]     cnt;
    logic                 tick;

    assign din_ext = {{(2*RLOG2){din[IW-1]}}, din};
    assign tick    = cen && (cnt == {RLOG2{1'b1}});

    // Combs run on the pre-update integ2. Integrator wrap cancels here because the
    // true comb result always fits in W bits.
    assign c1   = integ2 - dly1;
    assign c2   = c1 - dly2;
    assign c2_q = IW'(c2 >>> (2*RLOG2));

    always_ff @(posedge clk) begin
        if (rst) begin
            integ1     <= '0;
            integ2     <= '0;
            dly1       <= '0;
            dly2       <= '0;
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (cen) begin
                integ1 <= integ1 + din_ext;
                integ2 <= integ2 + integ1;
                cnt    <= cnt + 1'b1;
            end
            if (tick) begin
                dly1       <= integ2;
                dly2       <= c1;
                dout       <= c2_q;
                dout_valid <= 1'b1;
                // A pending sample nobody took is being replaced.
                if (dout_valid && !dout_ready)
                    overflow <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_jt89_cic_decim.sv
// Bench for jt89_cic_decim: each output is predicted from a triangular-window FIR view
// of the CIC, computed from the full input history since reset.
module tb_jt89_cic_decim;
    localparam int IW    = 11;
    localparam int RLOG2 = 4;
    localparam int R     = 16;

    logic                 clk = 1'b0;
    logic                 rst, cen, dout_ready, dout_valid, overflow;
    logic signed [IW-1:0] din, dout;

    int checks   = 0;
    int failures = 0;
    int xs[$];

    jt89_cic_decim #(.IW(IW), .RLOG2(RLOG2)) dut (
        .clk(clk), .rst(rst), .cen(cen), .din(din), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input int d);
        cen = c;
        din = d[IW-1:0];
        if (c && !rst) xs.push_back(d);
        step();
    endtask

    task automatic do_reset(input int n);
        int r;
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            r   = $urandom_range(0, 2047) - 1024;
            cen = 1'($urandom_range(0, 1));
            din = r[IW-1:0];
            step();
        end
        rst = 1'b0;
        cen = 1'b0;
        xs.delete();
    endtask

    function automatic int rnd_sample();
        return $urandom_range(0, 2047) - 1024;
    endfunction

    // Second integrator value seen at input index k: double running sum of the inputs.
    function automatic longint integ2_at(input int k);
        longint s = 0;
        for (int i = 0; i < k - 1 && i < xs.size(); i++)
            s += longint'(xs[i]) * longint'(k - 1 - i);
        return s;
    endfunction

    function automatic logic [IW-1:0] model_out(input int m);
        int     k  = R*m + R - 1;
        longint c2 = integ2_at(k) - 2*integ2_at(k - R) + integ2_at(k - 2*R);
        longint q  = c2 >>> (2*RLOG2);
        return q[IW-1:0];
    endfunction

    // mode 0: constant x, mode 1: +512/-512 alternating, mode 2: random full scale
    task automatic run_frames(input int mode, input int x, input int period, input int nout);
        int outs = 0, since = 0, clk_i = 0, ncen = 0, d, exp_since;
        int budget = (nout + 1)*R*period + 10;
        logic c;
        logic [IW-1:0] exp_v, steady;
        do_reset(1);
        dout_ready = 1'b1;
        steady = (mode == 0) ? x[IW-1:0] : '0;
        while (outs < nout && clk_i < budget) begin
            c = ((clk_i % period) == 0);
            if (mode == 0)      d = x;
            else if (mode == 1) d = (ncen % 2 == 1) ? -512 : 512;
            else                d = rnd_sample();
            if (c) ncen++;
            drive(c, d);
            clk_i++;
            since++;
            if (dout_valid) begin
                exp_since = (outs == 0) ? (R - 1)*period + 1 : R*period;
                checks++;
                if (since != exp_since) begin
                    failures++;
                    $display("FAIL valid_spacing mode=%0d period=%0d out=%0d got=%0d clks want=%0d",
                             mode, period, outs, since, exp_since);
                end
                exp_v = model_out(outs);
                checks++;
                if (dout !== exp_v) begin
                    failures++;
                    $display("FAIL dout_model mode=%0d x=%0d period=%0d out=%0d got=%h want=%h",
                             mode, x, period, outs, dout, exp_v);
                end
                if (mode != 2 && outs >= 2) begin
                    checks++;
                    if (dout !== steady) begin
                        failures++;
                        $display("FAIL dout_steady mode=%0d x=%0d out=%0d got=%h want=%h",
                                 mode, x, outs, dout, steady);
                    end
                end
                outs++;
                since = 0;
            end
        end
        checks++;
        if (outs < nout) begin
            failures++;
            $display("FAIL output_timeout mode=%0d got=%0d outputs want=%0d", mode, outs, nout);
        end
    endtask

    task automatic test_reset();
        do_reset(1);
        dout_ready = 1'b0;
        for (int i = 0; i < 2*R + 1; i++) drive(1'b1, rnd_sample());
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cen = 1'(i % 2 == 0);
            din = 11'sd300;
            step();
            checks++;
            if (dout_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid clk=%0d got=%b want=0", i, dout_valid);
            end
        end
        checks++;
        if (dout !== '0) begin
            failures++;
            $display("FAIL reset_dout got=%h want=0", dout);
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_overflow got=%b want=0", overflow);
        end
        rst = 1'b0;
        cen = 1'b0;
        xs.delete();
        dout_ready = 1'b1;
    endtask

    task automatic test_overflow();
        do_reset(1);
        dout_ready = 1'b0;
        for (int i = 0; i < R; i++) drive(1'b1, rnd_sample());
        checks++;
        if (dout_valid !== 1'b1 || overflow !== 1'b0 || dout !== model_out(0)) begin
            failures++;
            $display("FAIL ovf_first_tick got v=%b o=%b d=%h want v=1 o=0 d=%h",
                     dout_valid, overflow, dout, model_out(0));
        end
        for (int i = 0; i < 3; i++) drive(1'b0, 0);
        checks++;
        if (dout_valid !== 1'b1) begin
            failures++;
            $display("FAIL ovf_hold_valid got=%b want=1", dout_valid);
        end
        for (int i = 0; i < R; i++) drive(1'b1, rnd_sample());
        checks++;
        if (dout_valid !== 1'b1 || overflow !== 1'b1 || dout !== model_out(1)) begin
            failures++;
            $display("FAIL ovf_second_tick got v=%b o=%b d=%h want v=1 o=1 d=%h",
                     dout_valid, overflow, dout, model_out(1));
        end

        // Sink accepts on the very cycle the next sample lands.
        do_reset(1);
        dout_ready = 1'b0;
        for (int i = 0; i < 2*R - 1; i++) drive(1'b1, rnd_sample());
        dout_ready = 1'b1;
        drive(1'b1, rnd_sample());
        checks++;
        if (dout_valid !== 1'b1 || overflow !== 1'b0 || dout !== model_out(1)) begin
            failures++;
            $display("FAIL ready_on_tick got v=%b o=%b d=%h want v=1 o=0 d=%h",
                     dout_valid, overflow, dout, model_out(1));
        end
        drive(1'b0, 0);
        checks++;
        if (dout_valid !== 1'b0 || dout !== model_out(1)) begin
            failures++;
            $display("FAIL consume_clears got v=%b d=%h want v=0 d=%h",
                     dout_valid, dout, model_out(1));
        end
    endtask

    task automatic test_constant();
        run_frames(0, 100, 1, 5);
        run_frames(0, 100, 3, 4);
        run_frames(0, -300, 1, 4);
        run_frames(0, 1023, 1, 4);
        run_frames(0, -1024, 2, 4);
    endtask

    task automatic test_nyquist();
        run_frames(1, 0, 1, 5);
    endtask

    task automatic test_random();
        run_frames(2, 0, 1, 8);
        run_frames(2, 0, 2, 5);
    endtask

    task automatic test_midframe_reset();
        do_reset(1);
        dout_ready = 1'b1;
        for (int i = 0; i < 7; i++) drive(1'b1, rnd_sample());
        run_frames(2, 0, 1, 3);
    endtask

    initial begin
        rst        = 1'b1;
        cen        = 1'b0;
        din        = '0;
        dout_ready = 1'b1;
        step();
        test_reset();
        test_constant();
        test_nyquist();
        test_random();
        test_overflow();
        test_midframe_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
